// File: rtl/dvp2avl_stream_mc.sv
// dvp2avl_stream_mc: multi-camera DVP (UYVY) to Avalon-ST style video stream.
//
// All cameras share VSYNC/HREF timing. Each Y byte leaves as one beat on y_o
// together with the chroma byte latched just before it on cbcr_o. valid_cb_o
// or valid_cr_o says which chroma byte rides with the beat. sof_o and eof_o
// mark the first and last pixel of the frame. Line length, frame height and
// VSYNC placement are checked and reported as single-cycle status pulses.
//
// Optional build macro:
//   DVP_TEST_PATTERN_EN  adds tp_en_i. While it is high, channel k outputs
//                        y = pixel index + 16*k and cbcr = 8'h80. Timing and
//                        flags do not change.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pix_en_i            DVP sampling strobe; the other DVP inputs are only
//                       looked at while it is 1
//   vsync_i, href_i     frame sync (high in vertical blank), line valid
//   data_i              CH_NUM bytes, channel k in bits [8k+7:8k]
//   tp_en_i             test-pattern select (only with DVP_TEST_PATTERN_EN)
//   y_o, cbcr_o         luma and paired chroma per channel
//   valid_y_o           one beat per accepted Y byte
//   valid_cb_o          the chroma on this beat is Cb
//   valid_cr_o          the chroma on this beat is Cr
//   sof_o, eof_o        start and end of frame, qualified by valid_y_o
//   line_err_o          pulses when a line has the wrong length or is an extra line
//   frame_err_o         pulses when VSYNC rises before the frame completed
//   frame_done_o        pulses on the same cycle as eof_o
module dvp2avl_stream_mc #(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned LINE_W  = 1280,
  parameter int unsigned FRAME_H = 720
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_en_i,
  input  logic                vsync_i,
  input  logic                href_i,
  input  logic [CH_NUM*8-1:0] data_i,
`ifdef DVP_TEST_PATTERN_EN
  input  logic                tp_en_i,
`endif
  output logic [CH_NUM*8-1:0] y_o,
  output logic [CH_NUM*8-1:0] cbcr_o,
  output logic                valid_y_o,
  output logic                valid_cb_o,
  output logic                valid_cr_o,
  output logic                sof_o,
  output logic                eof_o,
  output logic                line_err_o,
  output logic                frame_err_o,
  output logic                frame_done_o
);

  localparam int unsigned DW    = CH_NUM * 8;
  localparam int unsigned PIX_W = $clog2(LINE_W + 1);
  localparam int unsigned LIN_W = $clog2(FRAME_H + 1);

  localparam logic [PIX_W-1:0] PIX_MAX  = PIX_W'(LINE_W);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LINE_W - 1);
  localparam logic [LIN_W-1:0] LIN_MAX  = LIN_W'(FRAME_H);
  localparam logic [LIN_W-1:0] LIN_LAST = LIN_W'(FRAME_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_FRAME  = 2'd2
  } state_t;

  state_t           state;
  logic             href_q;     // href at the previous sampling strobe
  logic [1:0]       phase;      // UYVY byte phase of the next byte in the line
  logic [PIX_W-1:0] pix_cnt;    // Y bytes seen in this line, stops at LINE_W
  logic [LIN_W-1:0] line_cnt;   // completed lines, stops at FRAME_H
  logic             pix_ovf;    // line had more than LINE_W Y bytes
  logic             line_act;   // a line started inside FRAME is in progress
  logic             eof_done;   // eof_o already issued for this frame
  logic [DW-1:0]    cb_lat;
  logic [DW-1:0]    cr_lat;

  logic             rise_c;
  logic             fall_c;
  logic             abort_c;
  logic             byte_c;
  logic             is_y_c;
  logic             pix_ok_c;
  logic             beat_c;
  logic             last_c;
  logic [1:0]       cur_phase_c;
  logic [DW-1:0]    y_src_c;
  logic [DW-1:0]    c_src_c;

  // Edge detection and classification of the byte being sampled this cycle.
  always_comb begin
    rise_c      = pix_en_i & href_i & ~href_q;
    fall_c      = pix_en_i & ~href_i & href_q;
    abort_c     = (state == ST_FRAME) & pix_en_i & vsync_i;
    // Bytes of a line that began before FRAME (line_act still 0) are ignored.
    byte_c      = (state == ST_FRAME) & pix_en_i & ~vsync_i & href_i
                  & (line_act | rise_c);
    cur_phase_c = rise_c ? 2'd0 : phase;
    is_y_c      = cur_phase_c[0];
    pix_ok_c    = (pix_cnt != PIX_MAX) & (line_cnt != LIN_MAX);
    beat_c      = byte_c & is_y_c & pix_ok_c;
    last_c      = (pix_cnt == PIX_LAST) & (line_cnt == LIN_LAST);
  end

  // Beat payload: live Y byte with the chroma latched earlier in the pair,
  // or the synthetic test pattern.
  always_comb begin
    y_src_c = data_i;
    c_src_c = cur_phase_c[1] ? cr_lat : cb_lat;
`ifdef DVP_TEST_PATTERN_EN
    if (tp_en_i) begin
      for (int k = 0; k < int'(CH_NUM); k++) begin
        y_src_c[8*k +: 8] = 8'(pix_cnt) + 8'(16 * k);
        c_src_c[8*k +: 8] = 8'h80;
      end
    end
`endif
  end

  // Frame state machine, counters, chroma latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      href_q       <= 1'b0;
      phase        <= 2'd0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      pix_ovf      <= 1'b0;
      line_act     <= 1'b0;
      eof_done     <= 1'b0;
      cb_lat       <= '0;
      cr_lat       <= '0;
      y_o          <= '0;
      cbcr_o       <= '0;
      valid_y_o    <= 1'b0;
      valid_cb_o   <= 1'b0;
      valid_cr_o   <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      line_err_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      valid_y_o    <= 1'b0;
      valid_cb_o   <= 1'b0;
      valid_cr_o   <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      line_err_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      frame_done_o <= 1'b0;

      if (pix_en_i) begin
        href_q <= href_i;
      end

      case (state)
        ST_IDLE: begin
          if (pix_en_i && vsync_i) begin
            state <= ST_VBLANK;
          end
        end

        ST_VBLANK: begin
          phase    <= 2'd0;
          pix_cnt  <= '0;
          line_cnt <= '0;
          pix_ovf  <= 1'b0;
          line_act <= 1'b0;
          eof_done <= 1'b0;
          if (pix_en_i && !vsync_i) begin
            state <= ST_FRAME;
          end
        end

        ST_FRAME: begin
          if (abort_c) begin
            // Frame ends here; an unfinished frame is flagged, and a line
            // still in progress is dropped.
            state    <= ST_VBLANK;
            line_act <= 1'b0;
            if (!eof_done) begin
              frame_err_o <= 1'b1;
            end
          end else begin
            if (rise_c) begin
              line_act <= 1'b1;
            end

            if (byte_c) begin
              phase <= cur_phase_c + 2'd1;
              if (cur_phase_c == 2'd0) begin
                cb_lat <= data_i;
              end
              if (cur_phase_c == 2'd2) begin
                cr_lat <= data_i;
              end
              if (is_y_c) begin
                if (pix_cnt == PIX_MAX) begin
                  pix_ovf <= 1'b1;
                end else begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
                end
              end
            end

            if (beat_c) begin
              valid_y_o  <= 1'b1;
              valid_cb_o <= ~cur_phase_c[1];
              valid_cr_o <= cur_phase_c[1];
              y_o        <= y_src_c;
              cbcr_o     <= c_src_c;
              sof_o      <= (pix_cnt == '0) && (line_cnt == '0);
              if (last_c) begin
                eof_o        <= 1'b1;
                frame_done_o <= 1'b1;
                eof_done     <= 1'b1;
              end
            end

            // End of line: check its length. The line is counted even when
            // it has the wrong length.
            if (fall_c && line_act) begin
              line_act   <= 1'b0;
              phase      <= 2'd0;
              pix_cnt    <= '0;
              pix_ovf    <= 1'b0;
              line_err_o <= (pix_cnt != PIX_MAX) | pix_ovf
                            | (line_cnt == LIN_MAX);
              if (line_cnt != LIN_MAX) begin
                line_cnt <= line_cnt + LIN_W'(1);
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp2avl_stream_mc.sv
// Self-checking bench for dvp2avl_stream_mc (CH_NUM=2, LINE_W=4, FRAME_H=2).
// A line/frame-level model predicts every output on every cycle. Literal
// expectations on the logged beats tie down the model.
module tb_dvp2avl_stream_mc;

  localparam int unsigned CH = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned FH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en_i;
  logic        vsync_i;
  logic        href_i;
  logic [15:0] data_i;
`ifdef DVP_TEST_PATTERN_EN
  logic        tp_en_i;
`endif
  logic [15:0] y_o;
  logic [15:0] cbcr_o;
  logic        valid_y_o, valid_cb_o, valid_cr_o, sof_o, eof_o;
  logic        line_err_o, frame_err_o, frame_done_o;

  dvp2avl_stream_mc #(.CH_NUM(CH), .LINE_W(LW), .FRAME_H(FH)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_en_i     (pix_en_i),
    .vsync_i      (vsync_i),
    .href_i       (href_i),
    .data_i       (data_i),
`ifdef DVP_TEST_PATTERN_EN
    .tp_en_i      (tp_en_i),
`endif
    .y_o          (y_o),
    .cbcr_o       (cbcr_o),
    .valid_y_o    (valid_y_o),
    .valid_cb_o   (valid_cb_o),
    .valid_cr_o   (valid_cr_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .line_err_o   (line_err_o),
    .frame_err_o  (frame_err_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit tp_mode = 1'b0;

  // Expected outputs for cycle exp_cyc.
  int          exp_cyc = -1;
  logic [7:0]  e_flags;
  logic [15:0] e_y, e_c;
  bit          e_data;

  // Model state, kept in terms of frames, lines and byte positions.
  int          m_st;     // 0: waiting for first vsync, 1: in blank, 2: in frame
  bit          m_prev, m_open, m_eof;
  int          m_bi, m_yc, m_ln;
  logic [15:0] m_cb, m_cr;

  // Logs of observed beats and pulses.
  int ylog[$], clog[$], y1log[$], c1log[$], slog[$], elog[$];
  int n_lerr, n_ferr, n_eof, n_sof, n_done;
  logic [7:0] got_f;

  task automatic model(input bit r, input bit pe, input bit vs, input bit hr,
                       input logic [15:0] d);
    logic [7:0]  f;
    logic [15:0] yv, cv;
    bit          dchk, rise, fall;
    int          ph, px;
    f = '0; yv = '0; cv = '0; dchk = 1'b0;
    if (r) begin
      m_st = 0; m_prev = 0; m_open = 0; m_eof = 0;
      m_bi = 0; m_yc = 0; m_ln = 0; m_cb = '0; m_cr = '0;
      dchk = 1'b1;
    end else if (pe) begin
      rise = hr && !m_prev;
      fall = !hr && m_prev;
      if (m_st == 0) begin
        if (vs) m_st = 1;
      end else if (m_st == 1) begin
        m_ln = 0; m_yc = 0; m_bi = 0; m_open = 0; m_eof = 0;
        if (!vs) m_st = 2;
      end else if (vs) begin
        if (!m_eof) f[0] = 1'b1;
        m_st = 1; m_open = 0;
      end else begin
        if (rise) begin m_open = 1; m_bi = 0; m_yc = 0; end
        if (hr && m_open) begin
          ph = m_bi % 4;
          if (ph == 0) m_cb = d;
          else if (ph == 2) m_cr = d;
          else begin
            px = m_yc;
            m_yc++;
            if (px < int'(LW) && m_ln < int'(FH)) begin
              f[7] = 1'b1;
              f[6] = (ph == 1);
              f[5] = (ph == 3);
              f[4] = (px == 0 && m_ln == 0);
              f[3] = (px == int'(LW) - 1 && m_ln == int'(FH) - 1);
              f[2] = f[3];
              if (f[3]) m_eof = 1;
              dchk = 1'b1;
              for (int k = 0; k < int'(CH); k++) begin
                if (tp_mode) begin
                  yv[8*k +: 8] = 8'(px) + 8'(16 * k);
                  cv[8*k +: 8] = 8'h80;
                end else begin
                  yv[8*k +: 8] = d[8*k +: 8];
                  cv[8*k +: 8] = (ph == 1) ? m_cb[8*k +: 8] : m_cr[8*k +: 8];
                end
              end
            end
          end
          m_bi++;
        end
        if (fall && m_open) begin
          f[1] = (m_yc != int'(LW)) || (m_ln >= int'(FH));
          m_ln++;
          m_open = 0;
        end
      end
      m_prev = hr;
    end
    e_flags = f; e_y = yv; e_c = cv; e_data = dchk;
    exp_cyc = cyc;
  endtask

  // Drive one clock's worth of inputs, then predict what that edge produces.
  task automatic step(input bit r, input bit pe, input bit vs, input bit hr,
                      input logic [15:0] d);
    reset = r; pix_en_i = pe; vsync_i = vs; href_i = hr; data_i = d;
`ifdef DVP_TEST_PATTERN_EN
    tp_en_i = tp_mode;
`endif
    @(posedge clk);
    #1;
    model(r, pe, vs, hr, d);
  endtask

  task automatic idle(input int n, input bit vs);
    for (int i = 0; i < n; i++) step(0, 1, vs, 0, 16'h0000);
  endtask

  task automatic frame_start();
    idle(3, 1);
    idle(2, 0);
  endtask

  // Channel 0 bytes are start, start+10, ...; channel 1 bytes are 100+start+i.
  task automatic send_line(input int n, input int start);
    for (int i = 0; i < n; i++)
      step(0, 1, 0, 1, {8'(100 + start + i), 8'(start + 10 * i)});
  endtask

  // Same bytes, with a strobe-low cycle after each byte carrying junk inputs.
  task automatic send_line_gap(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 1, {8'(100 + start + i), 8'(start + 10 * i)});
      step(0, 0, 1, 0, 16'hDEAD);
    end
  endtask

  task automatic clear_logs();
    ylog.delete(); clog.delete(); y1log.delete(); c1log.delete();
    slog.delete(); elog.delete();
    n_lerr = 0; n_ferr = 0; n_eof = 0; n_sof = 0; n_done = 0;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  // Per-cycle comparison against the model, plus logging.
  always @(negedge clk) begin
    if (exp_cyc == cyc) begin
      got_f = {valid_y_o, valid_cb_o, valid_cr_o, sof_o, eof_o,
               frame_done_o, line_err_o, frame_err_o};
      checks++;
      if (got_f !== e_flags) begin
        errors++;
        $display("FAIL flags cyc=%0d got=%b exp=%b", cyc, got_f, e_flags);
      end
      if (e_data) begin
        checks++;
        if (y_o !== e_y || cbcr_o !== e_c) begin
          errors++;
          $display("FAIL data cyc=%0d y=%h exp=%h cbcr=%h exp=%h",
                   cyc, y_o, e_y, cbcr_o, e_c);
        end
      end
      if (valid_y_o === 1'b1) begin
        ylog.push_back(int'(y_o[7:0]));
        clog.push_back(int'(cbcr_o[7:0]));
        y1log.push_back(int'(y_o[15:8]));
        c1log.push_back(int'(cbcr_o[15:8]));
        slog.push_back(int'(sof_o));
        elog.push_back(int'(eof_o));
      end
      if (line_err_o === 1'b1)   n_lerr++;
      if (frame_err_o === 1'b1)  n_ferr++;
      if (eof_o === 1'b1)        n_eof++;
      if (sof_o === 1'b1)        n_sof++;
      if (frame_done_o === 1'b1) n_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pix_en_i = 1'b0; vsync_i = 1'b0; href_i = 1'b0; data_i = '0;
`ifdef DVP_TEST_PATTERN_EN
    tp_en_i = 1'b0;
`endif
    step(1, 1, 0, 0, 16'h0000);
    step(1, 1, 0, 1, 16'h1234);
    chk("reset_y", int'(y_o), 0);
    chk("reset_valid", int'(valid_y_o), 0);

    // Lines before the first vsync are ignored.
    clear_logs();
    idle(2, 0); send_line(8, 10); idle(3, 0);
    chk("pre_vsync_beats", ylog.size(), 0);
    chk("pre_vsync_lerr", n_lerr, 0);

    // Normal frame of two lines of 10..80.
    frame_start();
    clear_logs();
    send_line(8, 10); idle(3, 0);
    send_line(8, 10); idle(3, 0);
    idle(3, 1);
    chk("s1_beats", ylog.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("s1_y", at(ylog, i), 20 * ((i % 4) + 1));
      chk("s1_cbcr", at(clog, i), 10 + 20 * (i % 4));
    end
    chk("s1_sof_first", at(slog, 0), 1);
    chk("s1_sof_count", n_sof, 1);
    chk("s1_eof_last", at(elog, 7), 1);
    chk("s1_eof_count", n_eof, 1);
    chk("s1_done_count", n_done, 1);
    chk("s1_lerr", n_lerr, 0);
    chk("s1_ferr", n_ferr, 0);

    // Short line, then a good last line, then an extra line that is dropped.
    frame_start();
    clear_logs();
    send_line(6, 10); idle(3, 0);
    send_line(8, 30); idle(3, 0);
    send_line(8, 50); idle(3, 0);
    idle(2, 1);
    chk("s2_lerr", n_lerr, 2);
    chk("s2_beats", ylog.size(), 7);
    chk("s2_y2", at(ylog, 2), 60);
    chk("s2_eof", n_eof, 1);
    chk("s2_ferr", n_ferr, 0);

    // Overlong line: fifth Y is dropped and flagged.
    frame_start();
    clear_logs();
    send_line(10, 10); idle(3, 0);
    send_line(8, 10); idle(3, 0);
    idle(2, 1);
    chk("long_beats", ylog.size(), 8);
    chk("long_y3", at(ylog, 3), 80);
    chk("long_lerr", n_lerr, 1);
    chk("long_eof", n_eof, 1);

    // vsync rises during line 1 while href is high.
    frame_start();
    clear_logs();
    send_line(8, 10); idle(2, 0);
    send_line(3, 10);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 16'h5A5A);
    idle(2, 1);
    chk("s3_ferr", n_ferr, 1);
    chk("s3_eof", n_eof, 0);
    chk("s3_beats", ylog.size(), 5);

    // Frame with the sampling strobe low every other cycle.
    frame_start();
    clear_logs();
    send_line_gap(8, 10); idle(3, 0);
    send_line_gap(8, 10); idle(3, 0);
    idle(2, 1);
    chk("gap_beats", ylog.size(), 8);
    chk("gap_y3", at(ylog, 3), 80);
    chk("gap_eof", n_eof, 1);
    chk("gap_ferr", n_ferr, 0);

    // Reset in the middle of line 0, then a clean frame.
    frame_start();
    send_line(3, 10);
    step(1, 1, 0, 1, {8'd104, 8'd40});
    chk("s5_rst_y", int'(y_o), 0);
    chk("s5_rst_flags", int'({valid_y_o, sof_o, eof_o, line_err_o, frame_err_o}), 0);
    clear_logs();
    send_line(5, 50); idle(3, 0);
    chk("s5_discard", ylog.size(), 0);
    frame_start();
    send_line(8, 10); idle(3, 0);
    send_line(8, 10); idle(3, 0);
    idle(2, 1);
    chk("s5_beats", ylog.size(), 8);
    chk("s5_sof", at(slog, 0), 1);
    chk("s5_eof", n_eof, 1);
    chk("s5_ferr", n_ferr, 0);

`ifdef DVP_TEST_PATTERN_EN
    // Test pattern replaces the data; timing is unchanged.
    tp_mode = 1'b1;
    frame_start();
    clear_logs();
    send_line(8, 10); idle(3, 0);
    send_line(8, 10); idle(3, 0);
    idle(2, 1);
    for (int i = 0; i < 4; i++) begin
      chk("tp_y1", at(y1log, i), 16 + i);
      chk("tp_y0", at(ylog, i), i);
      chk("tp_c1", at(c1log, i), 128);
    end
    chk("tp_eof", n_eof, 1);
    tp_mode = 1'b0;
`endif

    idle(2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp2avl_stream_mc.md
DVP2AVL_STREAM_MC -- requirements
Module: dvp2avl_stream_mc

Interface
REQ-001 Parameter CH_NUM, default 2: number of cameras; all cameras share VSYNC/HREF timing.
REQ-002 Parameter LINE_W, default 1280: expected pixels per line.
REQ-003 Parameter FRAME_H, default 720: expected lines per frame.
REQ-004 Port clk, input, 1: single clock for all logic; rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port pix_en_i, input, 1: DVP sampling strobe; vsync_i/href_i/data_i are evaluated only when 1.
REQ-007 Port vsync_i, input, 1: frame sync, high during vertical blank.
REQ-008 Port href_i, input, 1: line valid.
REQ-009 Port data_i, input, CH_NUM*8: DVP byte per channel; channel k occupies bits [8k+7:8k].
REQ-010 Port y_o, output, CH_NUM*8: luma per channel.
REQ-011 Port cbcr_o, output, CH_NUM*8: chroma per channel, paired with y_o.
REQ-012 Ports valid_y_o, valid_cb_o, valid_cr_o, outputs, 1 each: qualifiers; cbcr_o holds Cb when valid_cb_o=1 and Cr when valid_cr_o=1.
REQ-013 Ports sof_o, eof_o, outputs, 1 each: start-of-packet and end-of-packet, Avalon-ST style, qualified by valid_y_o.
REQ-014 Ports line_err_o, frame_err_o, frame_done_o, outputs, 1 each: single-cycle status pulses.

Function
REQ-015 Byte order in a line SHALL be Cb,Y,Cr,Y per pixel pair (UYVY); a 2-bit phase counter SHALL advance on each pix_en_i&href_i byte and reset to 0 on every href_i rising edge.
REQ-016 Cb and Cr bytes SHALL be latched per channel; on each Y byte the block SHALL output y_o = current byte and cbcr_o = latched chroma, with valid_y_o=1 one clk after the sampling cycle; valid_cb_o on phase 1 and valid_cr_o on phase 3.
REQ-017 A pixel counter of width $clog2(LINE_W+1) SHALL count Y bytes per line; a line counter of width $clog2(FRAME_H+1) SHALL count completed lines.
REQ-018 State machine: IDLE (after reset, waits for vsync_i=1) -> VBLANK (waits for vsync_i=0, clears counters) -> FRAME (accepts lines) -> VBLANK on vsync_i=1.
REQ-019 In IDLE and VBLANK, no valid_* output SHALL be asserted regardless of href_i.
REQ-020 sof_o SHALL be asserted with the first valid_y_o of line 0; eof_o with the valid_y_o of pixel LINE_W-1 on line FRAME_H-1; frame_done_o SHALL pulse on the same cycle as eof_o.
REQ-021 On an href_i falling edge where the pixel count is not equal to LINE_W, line_err_o SHALL pulse once; the line still counts.
REQ-022 Pixels beyond LINE_W-1 in a line and lines beyond FRAME_H-1 SHALL be dropped (no valid_*); line_err_o SHALL pulse at the href_i falling edge.
REQ-023 vsync_i rising in FRAME before eof_o has been issued SHALL pulse frame_err_o, suppress eof_o, and enter VBLANK; if href_i is high at that moment, the line is aborted with no further valid_*.
REQ-024 A single phase-1 or phase-3 byte occurring on the same cycle as an href_i falling edge SHALL still be output.

Reset
REQ-025 While reset=1, all outputs SHALL be 0, the state SHALL be IDLE, and all counters and the phase SHALL be 0.
REQ-026 A reset mid-frame SHALL take effect on the next clk, emit no eof_o, and discard data until the next vsync_i high/low sequence.

Configuration
REQ-027 Macro DVP_TEST_PATTERN_EN: when defined, an input port tp_en_i (1 bit) SHALL exist; while tp_en_i=1, channel k y_o SHALL be pixel_count[7:0]+16*k and cbcr_o SHALL be 8'h80, with all timing and flags unchanged.
REQ-028 When DVP_TEST_PATTERN_EN is undefined, port tp_en_i SHALL be absent and data SHALL always come from data_i.

Verification (LINE_W=4, FRAME_H=2, CH_NUM=2, pix_en_i=1)
REQ-029 Scenario 1: reset, vsync_i 1->0, two lines of bytes 10,20,30,40,50,60,70,80 on channel 0. Required: y_o ch0 = 20,40,60,80 with cbcr_o ch0 = 10,30,50,70; sof_o on the first Y; eof_o and frame_done_o on the 8th Y.
REQ-030 Scenario 2: line of only 3 Y bytes. Required: line_err_o pulses once at the href_i fall.
REQ-031 Scenario 3: vsync_i rises during line 1 with href_i high. Required: frame_err_o=1, no eof_o, no further valid_*.
REQ-032 Scenario 4: href_i active before the first vsync_i after reset. Required: no valid_* output.
REQ-033 Scenario 5: reset asserted mid-line 0. Required: all outputs 0 next clk; the next full frame is captured normally with sof_o.
REQ-034 Scenario 6 (DVP_TEST_PATTERN_EN, tp_en_i=1): Required: ch1 y_o = 16,17,18,19 and cbcr_o = 8'h80.
